// File: rtl/cs_seq_pkg.sv
// Shared encodings for the microprogram address sequencer: COND field codes,
// FSM states, control-store address width and the DECODE address builder.
package cs_seq_pkg;

    localparam int unsigned CSA_W = 11;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_WAIT_MEM = 2'b10
    } state_e;

    // Opcode dispatch: op[1:0] and op3[5:0] pick a 4-word slot in the upper half of the store.
    function automatic logic [CSA_W-1:0] decode_addr(input logic [31:0] ir);
        return {1'b1, ir[31:30], ir[24:19], 2'b00};
    endfunction

endpackage

// File: rtl/cs_next_address_mux.sv
// Combinational next-address selection from the microword COND field, PSR flags
// and instruction register.
module cs_next_address_mux
    import cs_seq_pkg::*;
(
    input  logic [2:0]       cond,
    input  logic [CSA_W-1:0] jump_addr,
    input  logic [CSA_W-1:0] csa,
    input  logic [3:0]       flags,
    input  logic [31:0]      ir,
    output logic [CSA_W-1:0] next_addr
);

    logic [CSA_W-1:0] csa_inc;
    logic             flag_n, flag_z, flag_v, flag_c;
    logic             unused_ir;

    assign csa_inc = csa + CSA_W'(1);
    assign {flag_n, flag_z, flag_v, flag_c} = flags;
    assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};

    always_comb begin
        next_addr = csa_inc;
        unique case (cond)
            COND_NEXT:   next_addr = csa_inc;
            COND_N:      next_addr = flag_n ? jump_addr : csa_inc;
            COND_Z:      next_addr = flag_z ? jump_addr : csa_inc;
            COND_V:      next_addr = flag_v ? jump_addr : csa_inc;
            COND_C:      next_addr = flag_c ? jump_addr : csa_inc;
            COND_IR13:   next_addr = ir[13] ? jump_addr : csa_inc;
            COND_JUMP:   next_addr = jump_addr;
            COND_DECODE: next_addr = decode_addr(ir);
            default:     next_addr = csa_inc;
        endcase
    end

endmodule

// File: rtl/cs_address_sequencer.sv
// Microprogram sequencer: holds the control-store address, stalls on memory
// accesses and strobes ADVANCE. Optional trap entry via CS_ADDRESS_SEQUENCER_TRAP_EN.
module cs_address_sequencer
    import cs_seq_pkg::*;
#(
    parameter int unsigned               CSA_DATAWIDTH = CSA_W,
    parameter logic [CSA_DATAWIDTH-1:0]  TRAP_VECTOR   = 11'h7F0
) (
    input  logic                     CS_ADDRESS_SEQUENCER_CLOCK_50,
    input  logic                     CS_ADDRESS_SEQUENCER_RESET_InLow,
    input  logic                     CS_ADDRESS_SEQUENCER_START,
    input  logic [2:0]               CS_ADDRESS_SEQUENCER_COND_InBus,
    input  logic [CSA_DATAWIDTH-1:0] CS_ADDRESS_SEQUENCER_JUMPADDR_InBus,
    input  logic                     CS_ADDRESS_SEQUENCER_RD,
    input  logic                     CS_ADDRESS_SEQUENCER_WR,
    input  logic                     CS_ADDRESS_SEQUENCER_MEM_ACK,
    input  logic [3:0]               CS_ADDRESS_SEQUENCER_FLAGS_InBus,
    input  logic [31:0]              CS_ADDRESS_SEQUENCER_IR_InBus,
`ifdef CS_ADDRESS_SEQUENCER_TRAP_EN
    input  logic                     CS_ADDRESS_SEQUENCER_TRAP_REQ,
`endif
    output logic [CSA_DATAWIDTH-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
    output logic                     CS_ADDRESS_SEQUENCER_MEM_REQ,
    output logic                     CS_ADDRESS_SEQUENCER_ADVANCE
`ifdef CS_ADDRESS_SEQUENCER_TRAP_EN
    ,
    output logic                     CS_ADDRESS_SEQUENCER_TRAP_ACK
`endif
);

    logic                     clk;
    logic                     rst_n;
    logic                     mem_rw;
    logic                     mem_ack;
    logic                     mem_req;
    logic                     advance;
    state_e                   state;
    logic [CSA_DATAWIDTH-1:0] csa;
    logic [CSA_DATAWIDTH-1:0] mux_next;
    logic [CSA_DATAWIDTH-1:0] next_addr;

    assign clk     = CS_ADDRESS_SEQUENCER_CLOCK_50;
    assign rst_n   = CS_ADDRESS_SEQUENCER_RESET_InLow;
    assign mem_rw  = CS_ADDRESS_SEQUENCER_RD | CS_ADDRESS_SEQUENCER_WR;
    assign mem_ack = CS_ADDRESS_SEQUENCER_MEM_ACK;

    cs_next_address_mux u_next_mux (
        .cond      (CS_ADDRESS_SEQUENCER_COND_InBus),
        .jump_addr (CS_ADDRESS_SEQUENCER_JUMPADDR_InBus),
        .csa       (csa),
        .flags     (CS_ADDRESS_SEQUENCER_FLAGS_InBus),
        .ir        (CS_ADDRESS_SEQUENCER_IR_InBus),
        .next_addr (mux_next)
    );

`ifdef CS_ADDRESS_SEQUENCER_TRAP_EN
    logic trap_take;

    // Traps are only taken at an instruction boundary, i.e. a completing DECODE microword.
    assign trap_take = advance && CS_ADDRESS_SEQUENCER_TRAP_REQ
                       && (CS_ADDRESS_SEQUENCER_COND_InBus == COND_DECODE);
    assign next_addr = trap_take ? TRAP_VECTOR : mux_next;
    assign CS_ADDRESS_SEQUENCER_TRAP_ACK = trap_take;
`else
    logic [CSA_DATAWIDTH-1:0] unused_trap_vector;

    assign unused_trap_vector = TRAP_VECTOR;
    assign next_addr = mux_next;
`endif

    always_comb begin
        mem_req = 1'b0;
        advance = 1'b0;
        unique case (state)
            ST_RUN: begin
                mem_req = mem_rw;
                advance = !mem_rw || mem_ack;
            end
            ST_WAIT_MEM: begin
                mem_req = 1'b1;
                advance = mem_ack;
            end
            default: begin
                mem_req = 1'b0;
                advance = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            csa   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (CS_ADDRESS_SEQUENCER_START) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        csa <= next_addr;
                    end else begin
                        state <= ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    if (advance) begin
                        csa   <= next_addr;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    csa   <= '0;
                end
            endcase
        end
    end

    assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = csa;
    assign CS_ADDRESS_SEQUENCER_MEM_REQ          = mem_req;
    assign CS_ADDRESS_SEQUENCER_ADVANCE          = advance;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed self-checking bench for cs_address_sequencer; trap cases are built
// when CS_ADDRESS_SEQUENCER_TRAP_EN is defined.
module tb_cs_address_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  cond;
    logic [10:0] jaddr;
    logic        rd, wr, ack;
    logic [3:0]  flags;
    logic [31:0] ir;
    logic [10:0] csa_out;
    logic        mem_req;
    logic        advance;
`ifdef CS_ADDRESS_SEQUENCER_TRAP_EN
    logic        trap_req;
    logic        trap_ack;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cs_address_sequencer dut (
        .CS_ADDRESS_SEQUENCER_CLOCK_50         (clk),
        .CS_ADDRESS_SEQUENCER_RESET_InLow      (rst_n),
        .CS_ADDRESS_SEQUENCER_START            (start),
        .CS_ADDRESS_SEQUENCER_COND_InBus       (cond),
        .CS_ADDRESS_SEQUENCER_JUMPADDR_InBus   (jaddr),
        .CS_ADDRESS_SEQUENCER_RD               (rd),
        .CS_ADDRESS_SEQUENCER_WR               (wr),
        .CS_ADDRESS_SEQUENCER_MEM_ACK          (ack),
        .CS_ADDRESS_SEQUENCER_FLAGS_InBus      (flags),
        .CS_ADDRESS_SEQUENCER_IR_InBus         (ir),
`ifdef CS_ADDRESS_SEQUENCER_TRAP_EN
        .CS_ADDRESS_SEQUENCER_TRAP_REQ         (trap_req),
        .CS_ADDRESS_SEQUENCER_TRAP_ACK         (trap_ack),
`endif
        .CS_ADDRESS_SEQUENCER_CSAddress_OutBus (csa_out),
        .CS_ADDRESS_SEQUENCER_MEM_REQ          (mem_req),
        .CS_ADDRESS_SEQUENCER_ADVANCE          (advance)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads an address through an unconditional jump; only valid in RUN.
    task automatic force_csa(input logic [10:0] addr);
        cond = 3'b110; jaddr = addr; rd = 0; wr = 0; ack = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; cond = 0; jaddr = 0; rd = 0; wr = 0; ack = 0;
        flags = 0; ir = 0;
`ifdef CS_ADDRESS_SEQUENCER_TRAP_EN
        trap_req = 0;
`endif
        tick(); tick();
        rst_n = 1; #1;
        checks++; if (csa_out !== 11'h000) begin errors++; $display("FAIL reset_csa got %h exp 000", csa_out); end
        checks++; if (advance !== 1'b0) begin errors++; $display("FAIL reset_adv got %b exp 0", advance); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_memreq got %b exp 0", mem_req); end
        // IDLE ignores the microword entirely.
        cond = 3'b110; jaddr = 11'h123; rd = 1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_memreq got %b exp 0", mem_req); end
        tick(); tick();
        checks++; if (csa_out !== 11'h000) begin errors++; $display("FAIL idle_hold got %h exp 000", csa_out); end
        checks++; if (advance !== 1'b0) begin errors++; $display("FAIL idle_adv got %b exp 0", advance); end
        rd = 0; cond = 0; jaddr = 0;
    endtask

    task automatic test_increment();
        logic [10:0] exp_seq [5];
        exp_seq = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4};
        start = 1; cond = 3'b000;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (csa_out !== exp_seq[i]) begin errors++; $display("FAIL inc_csa[%0d] got %h exp %h", i, csa_out, exp_seq[i]); end
            checks++; if (advance !== 1'b1) begin errors++; $display("FAIL inc_adv[%0d] got %b exp 1", i, advance); end
            tick();
        end
        checks++; if (csa_out !== 11'd5) begin errors++; $display("FAIL inc_csa5 got %h exp 005", csa_out); end
        // START is ignored once running.
        start = 1; tick(); start = 0;
        checks++; if (csa_out !== 11'd6) begin errors++; $display("FAIL start_ignored got %h exp 006", csa_out); end
        force_csa(11'd5);
    endtask

    task automatic test_cond_jump();
        logic [2:0]  t_cond [7];
        logic [3:0]  t_flag [7];
        logic        t_ir13 [7];
        logic [10:0] t_exp  [7];
        t_cond = '{3'b001, 3'b001, 3'b011, 3'b100, 3'b100, 3'b101, 3'b101};
        t_flag = '{4'b1000, 4'b0111, 4'b0010, 4'b0001, 4'b1110, 4'b0000, 4'b1111};
        t_ir13 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t_exp  = '{11'h200, 11'h041, 11'h200, 11'h200, 11'h041, 11'h200, 11'h041};

        cond = 3'b010; jaddr = 11'h100; flags = 4'b0100;
        tick();
        checks++; if (csa_out !== 11'h100) begin errors++; $display("FAIL z_taken got %h exp 100", csa_out); end
        force_csa(11'd5);
        cond = 3'b010; jaddr = 11'h100; flags = 4'b1011;
        tick();
        checks++; if (csa_out !== 11'h006) begin errors++; $display("FAIL z_not_taken got %h exp 006", csa_out); end

        for (int i = 0; i < 7; i++) begin
            force_csa(11'h040);
            cond = t_cond[i]; flags = t_flag[i]; jaddr = 11'h200;
            ir = 32'h0; ir[13] = t_ir13[i];
            tick();
            checks++; if (csa_out !== t_exp[i]) begin errors++; $display("FAIL cond_tbl[%0d] got %h exp %h", i, csa_out, t_exp[i]); end
        end
        flags = 0; ir = 0;
    endtask

    task automatic test_decode();
        force_csa(11'h010);
        cond = 3'b111; ir = 32'hBFC7_FFFF;
        tick();
        checks++; if (csa_out !== 11'h6E0) begin errors++; $display("FAIL decode_op10 got %h exp 6e0", csa_out); end
        ir = 32'h41C0_0000;
        tick();
        checks++; if (csa_out !== 11'h5E0) begin errors++; $display("FAIL decode_op01 got %h exp 5e0", csa_out); end
        ir = 0;
    endtask

    task automatic test_mem_stall();
        cond = 3'b000; rd = 1; wr = 0; ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stall_memreq[%0d] got %b exp 1", i, mem_req); end
            checks++; if (advance !== 1'b0) begin errors++; $display("FAIL stall_adv[%0d] got %b exp 0", i, advance); end
            tick();
            checks++; if (csa_out !== 11'h5E0) begin errors++; $display("FAIL stall_hold[%0d] got %h exp 5e0", i, csa_out); end
        end
        ack = 1; #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ack_memreq got %b exp 1", mem_req); end
        checks++; if (advance !== 1'b1) begin errors++; $display("FAIL ack_adv got %b exp 1", advance); end
        tick();
        rd = 0; ack = 0; #1;
        checks++; if (csa_out !== 11'h5E1) begin errors++; $display("FAIL ack_csa got %h exp 5e1", csa_out); end
        checks++; if (mem_req !== 1'b0 || advance !== 1'b1) begin errors++; $display("FAIL post_ack_run got req=%b adv=%b exp req=0 adv=1", mem_req, advance); end

        // RD and WR together with an immediate ack complete without a stall.
        rd = 1; wr = 1; ack = 1; #1;
        checks++; if (advance !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL rdwr_ack got req=%b adv=%b exp req=1 adv=1", mem_req, advance); end
        tick();
        checks++; if (csa_out !== 11'h5E2) begin errors++; $display("FAIL rdwr_csa got %h exp 5e2", csa_out); end

        // Flags are taken at the advancing cycle, not when the stall began.
        rd = 0; wr = 1; ack = 0; cond = 3'b010; jaddr = 11'h300; flags = 4'b0000;
        tick(); tick();
        flags = 4'b0100; ack = 1;
        tick();
        checks++; if (csa_out !== 11'h300) begin errors++; $display("FAIL wr_stall_flag got %h exp 300", csa_out); end
        wr = 0; ack = 0; cond = 0; flags = 0;
    endtask

    task automatic test_wrap();
        force_csa(11'h7FF);
        checks++; if (csa_out !== 11'h7FF) begin errors++; $display("FAIL wrap_pre got %h exp 7ff", csa_out); end
        cond = 3'b000;
        tick();
        checks++; if (csa_out !== 11'h000) begin errors++; $display("FAIL wrap got %h exp 000", csa_out); end
    endtask

    task automatic test_reset_mid_stall();
        force_csa(11'h0AA);
        cond = 3'b000; rd = 1; ack = 0;
        tick();
        checks++; if (mem_req !== 1'b1 || csa_out !== 11'h0AA) begin errors++; $display("FAIL pre_rst_stall got req=%b csa=%h exp req=1 csa=0aa", mem_req, csa_out); end
        rst_n = 0;
        tick();
        checks++; if (csa_out !== 11'h000) begin errors++; $display("FAIL rst_stall_csa got %h exp 000", csa_out); end
        checks++; if (mem_req !== 1'b0 || advance !== 1'b0) begin errors++; $display("FAIL rst_stall_out got req=%b adv=%b exp 0 0", mem_req, advance); end
        rst_n = 1; ack = 1;
        tick();
        checks++; if (csa_out !== 11'h000 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_stall_idle got csa=%h req=%b exp 000 0", csa_out, mem_req); end
        rd = 0; ack = 0;
    endtask

`ifdef CS_ADDRESS_SEQUENCER_TRAP_EN
    task automatic test_trap();
        start = 1; tick(); start = 0;
        cond = 3'b111; ir = 32'h81C0_0000; trap_req = 1; #1;
        checks++; if (trap_ack !== 1'b1) begin errors++; $display("FAIL trap_ack got %b exp 1", trap_ack); end
        tick();
        checks++; if (csa_out !== 11'h7F0) begin errors++; $display("FAIL trap_vec got %h exp 7f0", csa_out); end
        cond = 3'b000; #1;
        checks++; if (trap_ack !== 1'b0) begin errors++; $display("FAIL trap_nodecode_ack got %b exp 0", trap_ack); end
        tick();
        checks++; if (csa_out !== 11'h7F1) begin errors++; $display("FAIL trap_nodecode got %h exp 7f1", csa_out); end

        cond = 3'b111; rd = 1; ack = 0; trap_req = 0;
        tick();
        trap_req = 1; #1;
        checks++; if (trap_ack !== 1'b0) begin errors++; $display("FAIL trap_stall_ack got %b exp 0", trap_ack); end
        ack = 1; #1;
        checks++; if (trap_ack !== 1'b1) begin errors++; $display("FAIL trap_end_stall got %b exp 1", trap_ack); end
        tick();
        checks++; if (csa_out !== 11'h7F0) begin errors++; $display("FAIL trap_stall_vec got %h exp 7f0", csa_out); end
        rd = 0; ack = 0; trap_req = 0; #1;
        checks++; if (trap_ack !== 1'b0) begin errors++; $display("FAIL trap_ack_once got %b exp 0", trap_ack); end
        tick();
        checks++; if (csa_out !== 11'h6E0) begin errors++; $display("FAIL trap_off_decode got %h exp 6e0", csa_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_increment();
        test_cond_jump();
        test_decode();
        test_mem_stall();
        test_wrap();
        test_reset_mid_stall();
`ifdef CS_ADDRESS_SEQUENCER_TRAP_EN
        test_trap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
